uar_pkt_ctrl: RTL and testbench

- Controller that sequences the 162-bit UART packet receiver: holds it in reset while disabled, pulses its reset to re-arm after a stall, and detects packet completion from the receiver's ready line.
- Checks each completed packet's sync byte and queues accepted packets in a 2-entry buffer for a downstream consumer with a valid/ready handshake.
- Keeps saturating drop and timeout counters for debug readout.

---
 rtl/uar_pkt_ctrl_if.sv | 20 ++
 rtl/uar_pkt_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_uar_pkt_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uar_pkt_ctrl_if.sv
// Consumer-side packet handshake for uar_pkt_ctrl: head-of-queue data with valid/ready.
interface uar_pkt_ctrl_if #(
    parameter int unsigned PKT_LNGTH = 162
);
    logic [PKT_LNGTH-1:0] pkt_out;
    logic                 pkt_valid_out;
    logic                 pkt_ready_in;

    modport master (
        output pkt_out,
        output pkt_valid_out,
        input  pkt_ready_in
    );

    modport slave (
        input  pkt_out,
        input  pkt_valid_out,
        output pkt_ready_in
    );
endinterface

// File: rtl/uar_pkt_ctrl.sv
// Sequencer for the UART packet receiver: re-arm/watchdog FSM, sync check, 2-entry output queue.
// Optional even-parity acceptance check is enabled by defining UAR_PARITY_CHECK_EN.
module uar_pkt_ctrl #(
    parameter int unsigned PKT_LNGTH   = 162,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LOW_CYC = 2_000_000,
    parameter int unsigned RST_CYC     = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 en_in,
    input  logic                 rx_ready_in,
    input  logic [PKT_LNGTH-1:0] rx_data_in,
    output logic                 rx_rst_out,
    uar_pkt_ctrl_if.master       pkt_if,
    output logic [7:0]           drop_cnt_out,
    output logic [7:0]           tmo_cnt_out,
    output logic                 busy_out
);

    localparam int unsigned WD_W = (MAX_LOW_CYC > 1) ? $clog2(MAX_LOW_CYC) : 1;
    localparam int unsigned RC_W = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_LOW_CYC - 1);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYC - 1);

    typedef enum logic [3:0] {
        ST_DISABLED = 4'b0001,
        ST_REARM    = 4'b0010,
        ST_LISTEN   = 4'b0100,
        ST_BUSY     = 4'b1000
    } state_t;

    state_t               state_q, state_d;
    logic [RC_W-1:0]      rc_q, rc_d;
    logic [WD_W-1:0]      wdog_q, wdog_d;
    logic                 rdy_last_q, rdy_last_d;
    logic [PKT_LNGTH-1:0] head_q, head_d;
    logic                 head_vld_q, head_vld_d;
    logic [PKT_LNGTH-1:0] tail_q, tail_d;
    logic                 tail_vld_q, tail_vld_d;
    logic [7:0]           drop_q, drop_d;
    logic [7:0]           tmo_q, tmo_d;

    logic rise, fall, capture, tmo_inc;
    logic pop, push, full, hdr_ok, par_ok, drop_inc;

    assign rise = rx_ready_in & ~rdy_last_q;
    assign fall = ~rx_ready_in & rdy_last_q;

    assign hdr_ok = (rx_data_in[PKT_LNGTH-1 -: 8] == SYNC_BYTE);
`ifdef UAR_PARITY_CHECK_EN
    assign par_ok = ~(^rx_data_in);
`else
    assign par_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        rc_d       = '0;
        wdog_d     = wdog_q;
        rdy_last_d = rx_ready_in;
        capture    = 1'b0;
        tmo_inc    = 1'b0;
        case (state_q)
            ST_DISABLED: begin
                if (en_in) state_d = ST_REARM;
            end
            ST_REARM: begin
                // Receiver comes out of reset idle; pretend ready was already high.
                if (rc_q == RC_LAST) begin
                    state_d    = ST_LISTEN;
                    rdy_last_d = 1'b1;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            ST_LISTEN: begin
                if (fall) begin
                    state_d = ST_BUSY;
                    wdog_d  = '0;
                end
            end
            ST_BUSY: begin
                wdog_d = wdog_q + WD_W'(1);
                if (rise) begin
                    state_d = ST_LISTEN;
                    capture = 1'b1;
                end else if (wdog_q == WD_LAST) begin
                    state_d = ST_REARM;
                    tmo_inc = 1'b1;
                end
            end
            default: state_d = ST_DISABLED;
        endcase
        if (!en_in) begin
            state_d    = ST_DISABLED;
            capture    = 1'b0;
            tmo_inc    = 1'b0;
            rdy_last_d = rx_ready_in;
        end
    end

    assign pop      = head_vld_q & pkt_if.pkt_ready_in;
    assign full     = head_vld_q & tail_vld_q;
    assign push     = capture & hdr_ok & par_ok & (~full | pop);
    assign drop_inc = capture & ~push;

    always_comb begin
        head_d     = head_q;
        head_vld_d = head_vld_q;
        tail_d     = tail_q;
        tail_vld_d = tail_vld_q;
        case ({push, pop})
            2'b10: begin
                if (!head_vld_q) begin
                    head_d     = rx_data_in;
                    head_vld_d = 1'b1;
                end else begin
                    tail_d     = rx_data_in;
                    tail_vld_d = 1'b1;
                end
            end
            2'b01: begin
                if (tail_vld_q) begin
                    head_d     = tail_q;
                    tail_vld_d = 1'b0;
                end else begin
                    head_vld_d = 1'b0;
                end
            end
            2'b11: begin
                if (tail_vld_q) begin
                    head_d = tail_q;
                    tail_d = rx_data_in;
                end else begin
                    head_d = rx_data_in;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        drop_d = drop_q;
        tmo_d  = tmo_q;
        if (drop_inc && (drop_q != '1)) drop_d = drop_q + 8'd1;
        if (tmo_inc && (tmo_q != '1))   tmo_d  = tmo_q + 8'd1;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= ST_DISABLED;
            rc_q       <= '0;
            wdog_q     <= '0;
            rdy_last_q <= 1'b1;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            tail_q     <= '0;
            tail_vld_q <= 1'b0;
            drop_q     <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            wdog_q     <= wdog_d;
            rdy_last_q <= rdy_last_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            tail_q     <= tail_d;
            tail_vld_q <= tail_vld_d;
            drop_q     <= drop_d;
            tmo_q      <= tmo_d;
        end
    end

    assign rx_rst_out           = (state_q == ST_DISABLED) || (state_q == ST_REARM);
    assign busy_out             = (state_q == ST_BUSY);
    assign pkt_if.pkt_out       = head_q;
    assign pkt_if.pkt_valid_out = head_vld_q;
    assign drop_cnt_out         = drop_q;
    assign tmo_cnt_out          = tmo_q;

endmodule

// File: tb/tb_uar_pkt_ctrl.sv
// Randomised bench for uar_pkt_ctrl against a queue-based behavioural model.
module tb_uar_pkt_ctrl;

    localparam int unsigned W    = 162;
    localparam int unsigned MAXL = 1000;
    localparam int unsigned RSTC = 4;

    localparam int P_OFF    = 0;
    localparam int P_REARM  = 1;
    localparam int P_LISTEN = 2;
    localparam int P_BUSY   = 3;

    logic         clk_in = 1'b0;
    logic         rst_in;
    logic         en_in;
    logic         rx_ready_in;
    logic [W-1:0] rx_data_in;
    logic         rx_rst_out;
    logic         busy_out;
    logic [7:0]   drop_cnt_out;
    logic [7:0]   tmo_cnt_out;

    uar_pkt_ctrl_if #(.PKT_LNGTH(W)) pkt_if ();

    uar_pkt_ctrl #(
        .PKT_LNGTH  (W),
        .SYNC_BYTE  (8'hA5),
        .MAX_LOW_CYC(MAXL),
        .RST_CYC    (RSTC)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_in       (en_in),
        .rx_ready_in (rx_ready_in),
        .rx_data_in  (rx_data_in),
        .rx_rst_out  (rx_rst_out),
        .pkt_if      (pkt_if),
        .drop_cnt_out(drop_cnt_out),
        .tmo_cnt_out (tmo_cnt_out),
        .busy_out    (busy_out)
    );

    always #5 clk_in = ~clk_in;

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase, countdown/elapsed counters, packet queue.
    int           m_phase;
    int           m_left;
    int           m_low;
    bit           m_prev;
    logic [W-1:0] mq[$];
    int           m_drop;
    int           m_tmo;

    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] make_pkt(input logic [7:0] hdr);
        logic [W-1:0] d;
        d = '0;
        for (int i = 0; i < 6; i++) d = {d[W-33:0], 32'($urandom())};
        d[W-1 -: 8] = hdr;
        if (^d) d[0] = ~d[0];
        return d;
    endfunction

    task automatic model_reset();
        m_phase = P_OFF;
        m_left  = 0;
        m_low   = 0;
        m_prev  = 1'b1;
        mq.delete();
        m_drop  = 0;
        m_tmo   = 0;
    endtask

    task automatic model_step();
        bit pop, rise, fall, cap, ok;
        int sz;
        sz   = mq.size();
        pop  = (sz > 0) && (pkt_if.pkt_ready_in === 1'b1);
        rise = rx_ready_in && !m_prev;
        fall = !rx_ready_in && m_prev;
        cap  = 1'b0;
        m_prev = rx_ready_in;
        if (!en_in) begin
            m_phase = P_OFF;
        end else begin
            case (m_phase)
                P_OFF: begin
                    m_phase = P_REARM;
                    m_left  = RSTC;
                end
                P_REARM: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase = P_LISTEN;
                        m_prev  = 1'b1;
                    end
                end
                P_LISTEN: begin
                    if (fall) begin
                        m_phase = P_BUSY;
                        m_low   = 0;
                    end
                end
                default: begin
                    m_low++;
                    if (rise) begin
                        m_phase = P_LISTEN;
                        cap     = 1'b1;
                    end else if (m_low == MAXL) begin
                        m_phase = P_REARM;
                        m_left  = RSTC;
                        if (m_tmo < 255) m_tmo++;
                    end
                end
            endcase
        end
        if (pop) void'(mq.pop_front());
        if (cap) begin
            ok = (rx_data_in[W-1 -: 8] == 8'hA5);
`ifdef UAR_PARITY_CHECK_EN
            ok = ok && ((^rx_data_in) == 1'b0);
`endif
            if (!ok || (sz == 2 && !pop)) begin
                if (m_drop < 255) m_drop++;
            end else begin
                mq.push_back(rx_data_in);
            end
        end
    endtask

    task automatic compare_all();
        check_val("rx_rst", W'(rx_rst_out), W'((m_phase == P_OFF) || (m_phase == P_REARM)));
        check_val("busy", W'(busy_out), W'(m_phase == P_BUSY));
        check_val("valid", W'(pkt_if.pkt_valid_out), W'(mq.size() > 0));
        check_val("drop_cnt", W'(drop_cnt_out), W'(m_drop));
        check_val("tmo_cnt", W'(tmo_cnt_out), W'(m_tmo));
        if (mq.size() > 0) check_val("pkt_out", pkt_if.pkt_out, mq[0]);
    endtask

    task automatic step();
        @(posedge clk_in);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send(input logic [W-1:0] d, input int low, input int hold);
        rx_ready_in = 1'b0;
        repeat (low) step();
        rx_data_in  = d;
        rx_ready_in = 1'b1;
        repeat (hold) step();
    endtask

    task automatic check_reset_outputs();
        check_val("rst_rx_rst", W'(rx_rst_out), W'(1));
        check_val("rst_valid", W'(pkt_if.pkt_valid_out), W'(0));
        check_val("rst_pkt_out", pkt_if.pkt_out, '0);
        check_val("rst_drop", W'(drop_cnt_out), W'(0));
        check_val("rst_tmo", W'(tmo_cnt_out), W'(0));
        check_val("rst_busy", W'(busy_out), W'(0));
    endtask

    initial begin
        logic [W-1:0] d;
        logic [7:0]   hdr;
        int           low;

        rst_in              = 1'b1;
        en_in               = 1'b0;
        rx_ready_in         = 1'b1;
        rx_data_in          = '0;
        pkt_if.pkt_ready_in = 1'b0;
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) step();

        // Enable: re-arm pulse then listening.
        en_in = 1'b1;
        repeat (8) step();

        // Single good packet after 100 low cycles, consumer stalled.
        send(make_pkt(8'hA5), 100, 4);
        pkt_if.pkt_ready_in = 1'b1;
        repeat (2) step();
        pkt_if.pkt_ready_in = 1'b0;

        // Three good packets into a 2-entry queue, then drain.
        for (int i = 0; i < 3; i++) send(make_pkt(8'hA5), 10, 2);
        pkt_if.pkt_ready_in = 1'b1;
        repeat (2) step();
        pkt_if.pkt_ready_in = 1'b0;
        repeat (2) step();

        // Bad sync byte, then an odd-parity packet with a good header.
        send(make_pkt(8'h5A), 10, 2);
        d = make_pkt(8'hA5);
        d[0] = ~d[0];
        send(d, 10, 2);
        pkt_if.pkt_ready_in = 1'b1;
        repeat (3) step();
        pkt_if.pkt_ready_in = 1'b0;

        // Watchdog: ready held low past the limit.
        rx_ready_in = 1'b0;
        repeat (MAXL + 20) step();
        rx_ready_in = 1'b1;
        repeat (8) step();

        // Enable dropped on the rise cycle.
        rx_ready_in = 1'b0;
        repeat (20) step();
        rx_data_in  = make_pkt(8'hA5);
        rx_ready_in = 1'b1;
        en_in       = 1'b0;
        repeat (2) step();
        en_in = 1'b1;
        repeat (8) step();

        // Randomised traffic with random consumer back-pressure and enable drops.
        for (int p = 0; p < 60; p++) begin
            hdr = ($urandom_range(3) != 0) ? 8'hA5 : 8'($urandom());
            d   = make_pkt(hdr);
            if ($urandom_range(7) == 0) d[5] = ~d[5];
            low = int'($urandom_range(40, 1));
            rx_ready_in = 1'b0;
            for (int c = 0; c < low; c++) begin
                pkt_if.pkt_ready_in = 1'($urandom_range(1));
                step();
            end
            rx_data_in  = d;
            rx_ready_in = 1'b1;
            if ($urandom_range(9) == 0) en_in = 1'b0;
            for (int c = 0; c < 3; c++) begin
                pkt_if.pkt_ready_in = 1'($urandom_range(1));
                step();
                en_in = 1'b1;
            end
            repeat (6) step();
        end
        pkt_if.pkt_ready_in = 1'b0;

        // Drop counter saturation.
        for (int i = 0; i < 260; i++) send(make_pkt(8'h00), 1, 1);
        repeat (2) step();

        // Asynchronous reset with packets queued.
        pkt_if.pkt_ready_in = 1'b1;
        repeat (3) step();
        pkt_if.pkt_ready_in = 1'b0;
        send(make_pkt(8'hA5), 5, 2);
        send(make_pkt(8'hA5), 5, 2);
        @(posedge clk_in);
        #3;
        rst_in = 1'b1;
        #1;
        model_reset();
        check_reset_outputs();
        @(negedge clk_in);
        rst_in = 1'b0;
        en_in  = 1'b1;
        repeat (8) step();
        send(make_pkt(8'hA5), 5, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
